// File: rtl/gobou_out_writer.sv
// gobou_out_writer: packs the activated sample stream two-per-word and writes it from a programmed base.
// Optional zero-sample statistics are built only when GOBOU_WRITER_ZSTAT_EN is defined.
module gobou_out_writer #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int LWIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [AWIDTH-1:0]     base_addr,
  input  logic [LWIDTH-1:0]     out_size,
  input  logic                  in_en,
  input  logic [DWIDTH-1:0]     in_data,
  output logic                  mem_we,
  output logic [AWIDTH-1:0]     mem_addr,
  output logic [2*DWIDTH-1:0]   mem_wdata,
  output logic                  busy,
  output logic                  ack,
  output logic [LWIDTH-1:0]     zero_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LWIDTH-1:0] L_ONE = {{(LWIDTH-1){1'b0}}, 1'b1};
  localparam logic [AWIDTH-1:0] A_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  state_t                state_r, state_s;
  logic [AWIDTH-1:0]     base_r, base_s;
  logic [LWIDTH-1:0]     size_r, size_s;
  logic [LWIDTH-1:0]     cnt_r, cnt_s;
  logic [AWIDTH-1:0]     word_r, word_s;
  logic [DWIDTH-1:0]     lane0_r, lane0_s;
  logic                  we_r, we_s;
  logic [AWIDTH-1:0]     addr_r, addr_s;
  logic [2*DWIDTH-1:0]   wdata_r, wdata_s;
  logic                  ack_r, ack_s;
  logic                  busy_r, busy_s;
  logic [LWIDTH-1:0]     cnt_inc_s;
  logic                  last_s;
  logic [AWIDTH-1:0]     waddr_s;

  assign cnt_inc_s = cnt_r + L_ONE;
  assign last_s    = (cnt_inc_s == size_r);
  assign waddr_s   = base_r + word_r;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_s = state_r;
    base_s  = base_r;
    size_s  = size_r;
    cnt_s   = cnt_r;
    word_s  = word_r;
    lane0_s = lane0_r;
    we_s    = 1'b0;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    ack_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          base_s = base_addr;
          size_s = out_size;
          cnt_s  = {LWIDTH{1'b0}};
          word_s = {AWIDTH{1'b0}};
          if (out_size != {LWIDTH{1'b0}}) begin
            state_s = RUN;
          end else begin
            state_s = DONE;
            ack_s   = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (in_en) begin
          cnt_s = cnt_inc_s;
          if (cnt_r[0] == 1'b0) begin
            lane0_s = in_data;
            // A trailing even sample goes out immediately, zero-padded in the upper lane.
            if (last_s) begin
              we_s    = 1'b1;
              addr_s  = waddr_s;
              wdata_s = {{DWIDTH{1'b0}}, in_data};
              word_s  = word_r + A_ONE;
              state_s = FLUSH;
            end else begin
              state_s = RUN;
            end
          end else begin
            we_s    = 1'b1;
            addr_s  = waddr_s;
            wdata_s = {in_data, lane0_r};
            word_s  = word_r + A_ONE;
            if (last_s) begin
              state_s = DONE;
              ack_s   = 1'b1;
            end else begin
              state_s = RUN;
            end
          end
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        state_s = DONE;
        ack_s   = 1'b1;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      base_r  <= {AWIDTH{1'b0}};
      size_r  <= {LWIDTH{1'b0}};
      cnt_r   <= {LWIDTH{1'b0}};
      word_r  <= {AWIDTH{1'b0}};
      lane0_r <= {DWIDTH{1'b0}};
      we_r    <= 1'b0;
      addr_r  <= {AWIDTH{1'b0}};
      wdata_r <= {(2*DWIDTH){1'b0}};
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      base_r  <= base_s;
      size_r  <= size_s;
      cnt_r   <= cnt_s;
      word_r  <= word_s;
      lane0_r <= lane0_s;
      we_r    <= we_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      ack_r   <= ack_s;
      busy_r  <= busy_s;
    end
  end

  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign busy      = busy_r;
  assign ack       = ack_r;

`ifdef GOBOU_WRITER_ZSTAT_EN
  logic [LWIDTH-1:0] zcnt_r, zcnt_s;

  // Saturating count of zero (ReLU-clipped) samples; every RUN-state sample is accepted.
  always_comb begin
    if (state_r == IDLE && req) begin
      zcnt_s = {LWIDTH{1'b0}};
    end else if (state_r == RUN && in_en && in_data == {DWIDTH{1'b0}} &&
                 zcnt_r != {LWIDTH{1'b1}}) begin
      zcnt_s = zcnt_r + L_ONE;
    end else begin
      zcnt_s = zcnt_r;
    end
  end

  // Zero-count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      zcnt_r <= {LWIDTH{1'b0}};
    end else begin
      zcnt_r <= zcnt_s;
    end
  end

  assign zero_count = zcnt_r;
`else
  assign zero_count = {LWIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_gobou_out_writer.sv
// Scoreboard bench for gobou_out_writer: expected writes queued at stimulus time, popped on mem_we.
module tb_gobou_out_writer;

`ifdef GOBOU_WRITER_ZSTAT_EN
  localparam int ZSTAT = 1;
`else
  localparam int ZSTAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, req, in_en;
  logic [11:0] base_addr, out_size;
  logic [15:0] in_data;
  logic        mem_we, busy, ack;
  logic [11:0] mem_addr, zero_count;
  logic [31:0] mem_wdata;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  logic [43:0] exp_q[$];

  gobou_out_writer #(.DWIDTH(16), .AWIDTH(12), .LWIDTH(12)) dut (
    .clk(clk), .rst(rst), .req(req), .base_addr(base_addr), .out_size(out_size),
    .in_en(in_en), .in_data(in_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .ack(ack), .zero_count(zero_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and ack counter, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexp_we", {52'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [43:0] e;
        e = exp_q.pop_front();
        chk("waddr", {52'd0, mem_addr}, {52'd0, e[43:32]});
        chk("wdata", {32'd0, mem_wdata}, {32'd0, e[31:0]});
      end
    end
    if (ack === 1'b1) ack_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [11:0] a, input logic [15:0] hi, input logic [15:0] lo);
    exp_q.push_back({a, hi, lo});
  endtask

  task automatic start(input logic [11:0] b, input logic [11:0] n);
    req = 1'b1; base_addr = b; out_size = n;
    tick();
    req = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    in_en = 1'b1; in_data = d;
    tick();
    in_en = 1'b0;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_we"},    {63'd0, mem_we}, 64'd0);
    chk({tag, "_addr"},  {52'd0, mem_addr}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
    chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
    chk({tag, "_ack"},   {63'd0, ack}, 64'd0);
    chk({tag, "_zc"},    {52'd0, zero_count}, 64'd0);
  endtask

  initial begin
    int acks_before;
    rst = 1'b1; req = 1'b0; in_en = 1'b0; in_data = 16'd0;
    base_addr = 12'd0; out_size = 12'd0;
    tick(); tick();
    chk_idle_outs("rst");
    rst = 1'b0;
    tick();

    // Even vector, back-to-back samples.
    start(12'h010, 12'd4);
    chk("ev_busy", {63'd0, busy}, 64'd1);
    exp_wr(12'h010, 16'd2, 16'd1);
    exp_wr(12'h011, 16'd4, 16'd3);
    send(16'd1);
    send(16'd2);
    chk("ev_we1", {63'd0, mem_we}, 64'd1);
    send(16'd3);
    send(16'd4);
    chk("ev_we2", {63'd0, mem_we}, 64'd1);
    chk("ev_ack", {63'd0, ack}, 64'd1);
    tick();
    chk("ev_ack_off", {63'd0, ack}, 64'd0);
    chk("ev_busy_off", {63'd0, busy}, 64'd0);

    // Odd length with idle gaps and a zero sample.
    start(12'h020, 12'd3);
    exp_wr(12'h020, 16'd0, 16'd5);
    exp_wr(12'h021, 16'd0, 16'd7);
    send(16'd5); tick();
    send(16'd0); tick();
    send(16'd7);
    chk("od_flush_we", {63'd0, mem_we}, 64'd1);
    chk("od_ack_early", {63'd0, ack}, 64'd0);
    tick();
    chk("od_ack", {63'd0, ack}, 64'd1);
    chk("od_zc", {52'd0, zero_count}, 64'(ZSTAT));
    tick();
    chk("od_busy_off", {63'd0, busy}, 64'd0);
    chk("od_zc_hold", {52'd0, zero_count}, 64'(ZSTAT));

    // Zero length.
    start(12'h030, 12'd0);
    chk("z_ack", {63'd0, ack}, 64'd1);
    chk("z_busy", {63'd0, busy}, 64'd1);
    chk("z_zc_clr", {52'd0, zero_count}, 64'd0);
    tick();
    chk("z_ack_off", {63'd0, ack}, 64'd0);
    chk("z_busy_off", {63'd0, busy}, 64'd0);

    // req while busy must not relatch base or size.
    start(12'h040, 12'd2);
    req = 1'b1; base_addr = 12'h100; out_size = 12'd4;
    tick();
    req = 1'b0;
    exp_wr(12'h040, 16'h00BB, 16'h00AA);
    send(16'h00AA);
    send(16'h00BB);
    chk("ir_ack", {63'd0, ack}, 64'd1);
    tick();
    chk("ir_busy_off", {63'd0, busy}, 64'd0);

    // Address wrap, then excess samples.
    start(12'hFFF, 12'd4);
    exp_wr(12'hFFF, 16'd12, 16'd11);
    exp_wr(12'h000, 16'd14, 16'd13);
    send(16'd11); send(16'd12); send(16'd13); send(16'd14);
    chk("wr_ack", {63'd0, ack}, 64'd1);
    in_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 16'(15 + i);
      tick();
    end
    in_en = 1'b0;
    tick(); tick();
    chk("wr_pending", 64'(exp_q.size()), 64'd0);

    // Reset mid-vector.
    start(12'h050, 12'd4);
    exp_wr(12'h050, 16'd22, 16'd21);
    send(16'd21); send(16'd22); send(16'd23);
    acks_before = ack_cnt;
    rst = 1'b1;
    tick();
    chk_idle_outs("mid");
    rst = 1'b0;
    in_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'(30 + i);
      tick();
    end
    in_en = 1'b0;
    tick();
    chk("mid_no_ack", 64'(ack_cnt), 64'(acks_before));
    start(12'h060, 12'd2);
    exp_wr(12'h060, 16'd41, 16'd40);
    send(16'd40); send(16'd41);
    chk("mid_new_ack", {63'd0, ack}, 64'd1);
    tick(); tick();

    chk("final_pending", 64'(exp_q.size()), 64'd0);
    chk("final_acks", 64'(ack_cnt), 64'd6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
